// File: rtl/rf_pkg.sv
// Register-file constants and writeback record type shared by the
// writeback arbiter, its round-robin sub-block and their bench.
package rf_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_ZERO_ADDR  = 0;

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] addr;
    logic [RF_DATA_WIDTH-1:0] data;
  } rf_wb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above
// ptr, wrapping, wins a one-hot grant plus its binary index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbitration of writeback requesters onto the single register
// file write port. Optional read forwarding when RF_WB_BYPASS_EN is defined.
module reg_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef RF_WB_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0]           raddr1,
  input  logic [ADDR_WIDTH-1:0]           raddr2,
  input  logic [DATA_WIDTH-1:0]           rf_rdata1,
  input  logic [DATA_WIDTH-1:0]           rf_rdata2,
  output logic [DATA_WIDTH-1:0]           rdata1,
  output logic [DATA_WIDTH-1:0]           rdata2,
`endif
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_waddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic                            rf_wen,
  output logic [ADDR_WIDTH-1:0]           rf_waddr,
  output logic [DATA_WIDTH-1:0]           rf_wdata,
  output logic [31:0]                     wb_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_nxt;
  logic [NUM_REQ-1:0]    grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  accept_p0;
  logic                  commit_p0;
  logic [ADDR_WIDTH-1:0] waddr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] waddr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (PTR_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Stage p0: arbitration and selection of the winning write
  assign req_ready = rst ? '0 : grant;
  assign accept_p0 = |req_ready;
  assign waddr_p0  = req_waddr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata_p0  = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  // r0 writes complete the handshake but never reach the register file
  assign commit_p0 = accept_p0 && (waddr_p0 != ADDR_WIDTH'(RF_ZERO_ADDR));
  assign ptr_nxt   = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);

  // Stage p1: registered write port and commit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      wb_count <= '0;
    end else begin
      vld_p1 <= commit_p0;
      if (accept_p0) begin
        ptr <= ptr_nxt;
      end
      if (commit_p0) begin
        waddr_p1 <= waddr_p0;
        wdata_p1 <= wdata_p0;
        wb_count <= wb_count + 32'd1;
      end
    end
  end

  assign rf_wen   = vld_p1;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;

`ifdef RF_WB_BYPASS_EN
  assign rdata1 = (vld_p1 && (raddr1 == waddr_p1)) ? wdata_p1 : rf_rdata1;
  assign rdata2 = (vld_p1 && (raddr2 == waddr_p1)) ? wdata_p1 : rf_rdata2;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter (NUM_REQ=2); exercises the
// RF_WB_BYPASS_EN forwarding paths when that macro is defined.
module tb_reg_wb_arbiter;
  import rf_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_waddr;
  logic [63:0] req_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] wb_count;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rf_rdata1, rf_rdata2, rdata1, rdata2;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 0;
  rf_wb_t sb[$];

  reg_wb_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef RF_WB_BYPASS_EN
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .wb_count  (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every committed write on the port must match the oldest expectation
  always @(negedge clk) begin
    if (rf_wen === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
      end else begin
        rf_wb_t e;
        e = sb.pop_front();
        check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
        check("rf_wdata", rf_wdata, e.data);
      end
    end
  end

  // One cycle: present inputs, check grant, push expected commit, cross the edge
  task automatic step(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1, input logic [1:0] exp_rdy);
    logic commit;
    req_valid = v;
    req_waddr = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    check("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    commit = 1'b0;
    if (exp_rdy[0] && a0 != 5'd0) begin
      sb.push_back('{addr: a0, data: d0});
      commit = 1'b1;
    end
    if (exp_rdy[1] && a1 != 5'd0) begin
      sb.push_back('{addr: a1, data: d1});
      commit = 1'b1;
    end
    if (commit) exp_count++;
    @(posedge clk);
    #1;
    if (rst) exp_count = 0;
    check("rf_wen", {31'd0, rf_wen}, {31'd0, commit});
    check("wb_count", wb_count, exp_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 2'b11;
    req_waddr = {5'd4, 5'd3};
    req_wdata = {32'hBBBB_0002, 32'hAAAA_0001};
`ifdef RF_WB_BYPASS_EN
    raddr1    = 5'd0;
    raddr2    = 5'd0;
    rf_rdata1 = 32'd0;
    rf_rdata2 = 32'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_wb_count", wb_count, 32'd0);
    check("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);

    // Release reset with both requesters pending: 0 first, then alternating
    rst = 1'b0;
    step(2'b11, 5'd3, 32'hAAAA_0001, 5'd4, 32'hBBBB_0002, 2'b01);
    step(2'b11, 5'd6, 32'hCCCC_0003, 5'd4, 32'hBBBB_0002, 2'b10);
    step(2'b11, 5'd6, 32'hCCCC_0003, 5'd9, 32'hDDDD_0004, 2'b01);
    step(2'b11, 5'd6, 32'hEEEE_0005, 5'd9, 32'hDDDD_0004, 2'b10);
    check("count_after_contention", wb_count, 32'd4);

    // Idle: no grant, port holds the last committed write
    step(2'b00, 5'd1, 32'h0, 5'd2, 32'h0, 2'b00);
    check("hold_waddr", {27'd0, rf_waddr}, 32'd9);
    check("hold_wdata", rf_wdata, 32'hDDDD_0004);

    // Single write; then a lone req0 with ptr at 1 wraps around
    step(2'b01, 5'd5, 32'h1234_5678, 5'd0, 32'h0, 2'b01);
    step(2'b01, 5'd13, 32'h0000_00D0, 5'd0, 32'h0, 2'b01);

    // r0 write from requester 1: handshake completes, nothing committed
    step(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFF_FFFF, 2'b10);
    check("r0_count", wb_count, 32'd6);

    // Back-to-back writes to r20: the later one is last on the port
    step(2'b01, 5'd20, 32'h1111_1111, 5'd0, 32'h0, 2'b01);
    step(2'b10, 5'd0, 32'h0, 5'd20, 32'h2222_2222, 2'b10);
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
    check("last_wins_wdata", rf_wdata, 32'h2222_2222);

    // Mid-operation reset right after a handshake
    step(2'b01, 5'd21, 32'h2121_2121, 5'd0, 32'h0, 2'b01);
    rst = 1'b1;
    step(2'b10, 5'd0, 32'h0, 5'd22, 32'h2222_0022, 2'b00);
    check("midrst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    rst = 1'b0;
    step(2'b11, 5'd23, 32'h2323_2323, 5'd24, 32'h2424_2424, 2'b01);
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);

`ifdef RF_WB_BYPASS_EN
    raddr1    = 5'd7;
    rf_rdata1 = 32'd0;
    raddr2    = 5'd8;
    rf_rdata2 = 32'h0000_0055;
    step(2'b01, 5'd7, 32'hA5A5_A5A5, 5'd0, 32'h0, 2'b01);
    check("bypass_rdata1", rdata1, 32'hA5A5_A5A5);
    check("bypass_rdata2", rdata2, 32'h0000_0055);
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
    check("nobypass_rdata1", rdata1, 32'd0);
`endif

    @(negedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
